// File: rtl/branch_unit_bht.sv
// rtl/branch_unit_bht.sv - EX-stage branch resolver with 2-bit BHT predictor, registered redirect and stats
module branch_unit_bht #(
    parameter int XLEN      = 16,
    parameter int BHT_DEPTH = 64,
    parameter int PC_SHIFT  = 1,
    parameter int BHT_INIT  = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic             ex_jump,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_pred_taken,
    output logic             redirect,
    output logic             redirect_taken,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);
    localparam int         IDX_W    = $clog2(BHT_DEPTH);
    localparam logic [1:0] CTR_INIT = 2'(BHT_INIT);

    logic [1:0]       bht_q [BHT_DEPTH];
    logic             redirect_q, redirect_d;
    logic             redirect_taken_q, redirect_taken_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic             cond, cond_legal, actual, active, mispredict, counted, bht_upd;

    // Shifting the whole PC before truncating keeps the index a plain bit slice.
    assign if_idx        = IDX_W'(if_pc >> PC_SHIFT);
    assign ex_idx        = IDX_W'(ex_pc >> PC_SHIFT);
    assign if_pred_taken = bht_q[if_idx][1];

    always_comb begin
        cond       = 1'b0;
        cond_legal = 1'b1;
        case (ex_funct3)
            3'b000:  cond = (ex_rs1 == ex_rs2);
            3'b001:  cond = (ex_rs1 != ex_rs2);
            3'b100:  cond = ($signed(ex_rs1) <  $signed(ex_rs2));
            3'b101:  cond = ($signed(ex_rs1) >= $signed(ex_rs2));
            3'b110:  cond = (ex_rs1 <  ex_rs2);
            3'b111:  cond = (ex_rs1 >= ex_rs2);
            default: cond_legal = 1'b0;
        endcase
    end

    assign actual     = ex_jump | (ex_branch & cond);
    assign active     = ex_valid & (ex_branch | ex_jump);
    assign mispredict = active & (actual != ex_pred_taken);
    assign counted    = active & (ex_jump | cond_legal);
    assign bht_upd    = active & ex_branch & ~ex_jump & cond_legal;

    always_comb begin
        redirect_d       = mispredict;
        redirect_taken_d = actual;
        branch_cnt_d     = branch_cnt_q;
        mispred_cnt_d    = mispred_cnt_q;
        if (counted && (branch_cnt_q != {CNT_W{1'b1}})) begin
            branch_cnt_d = branch_cnt_q + 1'b1;
        end
        if (mispredict && (mispred_cnt_q != {CNT_W{1'b1}})) begin
            mispred_cnt_d = mispred_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_q       <= 1'b0;
            redirect_taken_q <= 1'b0;
            branch_cnt_q     <= '0;
            mispred_cnt_q    <= '0;
        end else begin
            redirect_q       <= redirect_d;
            redirect_taken_q <= redirect_taken_d;
            branch_cnt_q     <= branch_cnt_d;
            mispred_cnt_q    <= mispred_cnt_d;
        end
    end

    // Saturating 2-bit counters; the IF lookup sees the pre-edge value (no bypass).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= CTR_INIT;
            end
        end else if (bht_upd) begin
            if (actual && (bht_q[ex_idx] != 2'd3)) begin
                bht_q[ex_idx] <= bht_q[ex_idx] + 2'd1;
            end else if (!actual && (bht_q[ex_idx] != 2'd0)) begin
                bht_q[ex_idx] <= bht_q[ex_idx] - 2'd1;
            end
        end
    end

    assign redirect       = redirect_q;
    assign redirect_taken = redirect_taken_q;
    assign branch_cnt     = branch_cnt_q;
    assign mispred_cnt    = mispred_cnt_q;
endmodule

// File: tb/tb_branch_unit_bht.sv
// tb/tb_branch_unit_bht.sv - randomized and directed self-checking bench for branch_unit_bht
module tb_branch_unit_bht;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] if_pc = '0;
    logic        ex_valid = 1'b0, ex_branch = 1'b0, ex_jump = 1'b0, ex_pred_taken = 1'b0;
    logic [2:0]  ex_funct3 = '0;
    logic [15:0] ex_rs1 = '0, ex_rs2 = '0, ex_pc = '0;

    logic        pred_a, red_a, rtk_a, pred_b, red_b, rtk_b;
    logic [15:0] bcnt_a, mcnt_a;
    logic [3:0]  bcnt_b, mcnt_b;

    int n_checks = 0;
    int n_errors = 0;

    branch_unit_bht dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(pred_a),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_funct3(ex_funct3),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
        .redirect(red_a), .redirect_taken(rtk_a), .branch_cnt(bcnt_a), .mispred_cnt(mcnt_a)
    );

    branch_unit_bht #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(pred_b),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_funct3(ex_funct3),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
        .redirect(red_b), .redirect_taken(rtk_b), .branch_cnt(bcnt_b), .mispred_cnt(mcnt_b)
    );

    always #5 clk = ~clk;

    // Reference model: counters as integers, table as an array of small ints.
    int m_bht [64];
    bit m_red, m_rtk;
    int m_bcnt, m_mcnt;

    function automatic int idx_of(input logic [15:0] pc);
        return (int'(pc) / 2) % 64;
    endfunction

    function automatic void resolve(input logic [2:0] f3, input logic [15:0] a, input logic [15:0] b,
                                    output bit taken, output bit legal);
        int sa, sb;
        sa = (int'(a) >= 32768) ? int'(a) - 65536 : int'(a);
        sb = (int'(b) >= 32768) ? int'(b) - 65536 : int'(b);
        legal = 1'b1;
        case (f3)
            3'd0: taken = (a == b);
            3'd1: taken = (a != b);
            3'd4: taken = (sa < sb);
            3'd5: taken = (sa >= sb);
            3'd6: taken = (int'(a) < int'(b));
            3'd7: taken = (int'(a) >= int'(b));
            default: begin taken = 1'b0; legal = 1'b0; end
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit tk, lg, act, on;
        if (rst) begin
            for (int i = 0; i < 64; i++) m_bht[i] <= 1;
            m_red <= 1'b0; m_rtk <= 1'b0; m_bcnt <= 0; m_mcnt <= 0;
        end else begin
            resolve(ex_funct3, ex_rs1, ex_rs2, tk, lg);
            act = ex_jump || (ex_branch && tk);
            on  = ex_valid && (ex_branch || ex_jump);
            m_red <= on && (act != ex_pred_taken);
            m_rtk <= act;
            if (on && (ex_jump || lg)) m_bcnt <= m_bcnt + 1;
            if (on && (act != ex_pred_taken)) m_mcnt <= m_mcnt + 1;
            if (on && !ex_jump && ex_branch && lg) begin
                if (act) m_bht[idx_of(ex_pc)] <= (m_bht[idx_of(ex_pc)] < 3) ? m_bht[idx_of(ex_pc)] + 1 : 3;
                else     m_bht[idx_of(ex_pc)] <= (m_bht[idx_of(ex_pc)] > 0) ? m_bht[idx_of(ex_pc)] - 1 : 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        bit ep;
        ep = (m_bht[idx_of(if_pc)] >= 2);
        chk("pred16", 32'(pred_a), 32'(ep));
        chk("pred4", 32'(pred_b), 32'(ep));
        chk("redirect16", 32'(red_a), 32'(m_red));
        chk("redirect4", 32'(red_b), 32'(m_red));
        if (m_red) chk("redirect_taken", 32'(rtk_a), 32'(m_rtk));
        chk("branch_cnt16", 32'(bcnt_a), 32'((m_bcnt > 65535) ? 65535 : m_bcnt));
        chk("mispred_cnt16", 32'(mcnt_a), 32'((m_mcnt > 65535) ? 65535 : m_mcnt));
        chk("branch_cnt4", 32'(bcnt_b), 32'((m_bcnt > 15) ? 15 : m_bcnt));
        chk("mispred_cnt4", 32'(mcnt_b), 32'((m_mcnt > 15) ? 15 : m_mcnt));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit br, input bit jp, input logic [2:0] f3, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] pc, input bit pr);
        ex_valid = 1'b1; ex_branch = br; ex_jump = jp; ex_funct3 = f3;
        ex_rs1 = a; ex_rs2 = b; ex_pc = pc; ex_pred_taken = pr;
        step();
    endtask

    task automatic idle();
        ex_valid = 1'b0; ex_branch = 1'b0; ex_jump = 1'b0;
        step();
    endtask

    initial begin
        int b0, m0;
        #1 rst = 1'b1;
        if_pc = 16'h0040;
        step();
        chk("reset_pred", 32'(pred_a), 32'd0);
        chk("reset_redirect", 32'(red_a), 32'd0);
        chk("reset_rtaken", 32'(rtk_a), 32'd0);
        chk("reset_bcnt", 32'(bcnt_a), 32'd0);
        rst = 1'b0;
        step();

        // Mispredict then reset while redirect is high.
        drive(1, 0, 3'b000, 16'd1, 16'd1, 16'h0050, 1'b0);
        chk("pre_reset_redirect", 32'(red_a), 32'd1);
        rst = 1'b1;
        #1 chk("async_clear_redirect", 32'(red_a), 32'd0);
        chk("async_clear_bcnt", 32'(bcnt_a), 32'd0);
        step();
        rst = 1'b0;
        idle();

        // BEQ taken, predicted not taken.
        if_pc = 16'h0010;
        drive(1, 0, 3'b000, 16'd5, 16'd5, 16'h0010, 1'b0);
        chk("beq_redirect", 32'(red_a), 32'd1);
        chk("beq_rtaken", 32'(rtk_a), 32'd1);
        chk("beq_ctr8", 32'(m_bht[8]), 32'd2);
        chk("beq_pred", 32'(pred_a), 32'd1);
        idle();
        chk("beq_redirect_drop", 32'(red_a), 32'd0);

        // Signed vs unsigned compare.
        drive(1, 0, 3'b100, 16'hFFFF, 16'h0001, 16'h0020, 1'b1);
        chk("blt_redirect", 32'(red_a), 32'd0);
        drive(1, 0, 3'b110, 16'hFFFF, 16'h0001, 16'h0022, 1'b1);
        chk("bltu_redirect", 32'(red_a), 32'd1);
        chk("bltu_rtaken", 32'(rtk_a), 32'd0);
        idle();

        // Saturation of one counter.
        if_pc = 16'h0030;
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 3'b101, 16'd3, 16'd3, 16'h0030, 1'b1);
            chk("bge_ctr", 32'(m_bht[24]), (i == 0) ? 32'd2 : 32'd3);
        end
        drive(1, 0, 3'b101, 16'd1, 16'd2, 16'h0030, 1'b1);
        chk("bge_nt_ctr", 32'(m_bht[24]), 32'd2);
        chk("bge_nt_pred", 32'(pred_a), 32'd1);
        idle();

        // Jump: redirect, count, no table change; illegal funct3: no count/update.
        b0 = int'(bcnt_a);
        m0 = int'(mcnt_a);
        drive(0, 1, 3'b000, 16'd0, 16'd0, 16'h0010, 1'b0);
        chk("jal_redirect", 32'(red_a), 32'd1);
        chk("jal_rtaken", 32'(rtk_a), 32'd1);
        chk("jal_ctr8", 32'(m_bht[8]), 32'd2);
        chk("jal_bcnt", 32'(bcnt_a), 32'(b0 + 1));
        drive(1, 0, 3'b011, 16'd7, 16'd7, 16'h0010, 1'b0);
        chk("illegal_bcnt", 32'(bcnt_a), 32'(b0 + 1));
        chk("illegal_ctr8", 32'(m_bht[8]), 32'd2);
        drive(1, 0, 3'b010, 16'd7, 16'd7, 16'h0010, 1'b1);
        chk("illegal_mispred", 32'(red_a), 32'd1);
        chk("illegal_mcnt", 32'(mcnt_a), 32'(m0 + 2));
        chk("illegal_bcnt2", 32'(bcnt_a), 32'(b0 + 1));
        idle();

        // Narrow counters saturate.
        for (int i = 0; i < 20; i++) drive(0, 1, 3'b000, 16'd0, 16'd0, 16'h0002, 1'b0);
        chk("mcnt4_sat", 32'(mcnt_b), 32'hF);
        chk("bcnt4_sat", 32'(bcnt_b), 32'hF);
        idle();

        // Same-index lookup and update: old value during the cycle.
        if_pc = 16'h0040;
        ex_valid = 1'b1; ex_branch = 1'b1; ex_jump = 1'b0; ex_funct3 = 3'b000;
        ex_rs1 = 16'd9; ex_rs2 = 16'd9; ex_pc = 16'h0040; ex_pred_taken = 1'b0;
        @(negedge clk);
        chk("same_idx_old", 32'(pred_a), 32'd0);
        step();
        chk("same_idx_new", 32'(pred_a), 32'd1);
        idle();

        // Randomized phase.
        for (int c = 0; c < 3000; c++) begin
            logic [15:0] pc;
            pc = 16'($urandom_range(0, 15) * 2);
            if ($urandom_range(0, 1) == 1) pc = pc | 16'h0080;
            if ($urandom_range(0, 3) == 0) pc = pc | 16'h8000;
            ex_valid      = ($urandom_range(0, 3) != 0);
            ex_branch     = ($urandom_range(0, 4) != 0);
            ex_jump       = ($urandom_range(0, 5) == 0);
            ex_funct3     = 3'($urandom_range(0, 7));
            ex_rs1        = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 3));
            ex_rs2        = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 3));
            ex_pc         = pc;
            ex_pred_taken = 1'($urandom_range(0, 1));
            if_pc         = ($urandom_range(0, 2) == 0) ? pc : 16'($urandom_range(0, 63) * 2);
            rst           = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0;
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
